// File: rtl/dispatch_ctrl_pkg.sv
// Shared dispatch definitions: FSM states, FU-class bit positions, queue depth default.
package dispatch_ctrl_pkg;
  localparam int QDEPTH_DEF = 8;
  localparam int NUM_FU     = 6;

  localparam int FU_ALU1   = 0;
  localparam int FU_ALU2   = 1;
  localparam int FU_MULDIV = 2;
  localparam int FU_BR     = 3;
  localparam int FU_LSU    = 4;
  localparam int FU_SP     = 5;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_SECOND,
    ST_SERIAL_WAIT
  } state_e;
endpackage

// File: rtl/dispatch_credit.sv
// One issue-queue credit counter: starts full, push takes a credit, free returns one.
// Credit updates land at the next edge; flush or reset refill it to QDEPTH.
module dispatch_credit
  import dispatch_ctrl_pkg::*;
#(
  parameter int QDEPTH = QDEPTH_DEF,
  localparam int CW    = $clog2(QDEPTH + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          push,
  input  logic          free,
  output logic [CW-1:0] credit,
  output logic          avail
);
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  logic [CW-1:0] credit_q, credit_d;

  always_comb begin
    credit_d = credit_q;
    if (flush) begin
      credit_d = FULL;
    end else if (push && !free) begin
      credit_d = (credit_q == '0) ? '0 : credit_q - 1'b1;
    end else if (free && !push) begin
      credit_d = (credit_q >= FULL) ? FULL : credit_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) credit_q <= FULL;
    else         credit_q <= credit_d;
  end

  assign credit = credit_q;
  assign avail  = (credit_q != '0);

  // A free with no entry outstanding means the queue returned more than it took.
  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn || flush)
    (free && !push) |-> (credit_q < FULL));
  a_no_underflow: assert property (@(posedge clk) disable iff (!resetn || flush)
    push |-> (credit_q != '0));
endmodule

// File: rtl/dispatch_ctrl.sv
// Dispatch FSM: pushes decoded uops into one-hot FU queues, zero-latency, stalls on no credit.
// Optional serial-op hold behind an empty ROB is built only with DISPATCH_SERIALIZE_EN.
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int QDEPTH = QDEPTH_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              rob_empty,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NUM_FU-1:0] in_class,
  input  logic              in_dual,
  input  logic              in_serial,
  output logic              is_inst2,
  output logic [NUM_FU-1:0] q_push,
  input  logic [NUM_FU-1:0] q_free
);
  localparam int CW = $clog2(QDEPTH + 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     credit [NUM_FU];
  logic [NUM_FU-1:0] avail;
  logic              class_ok, target_avail, serial_hold;
  logic              push_en, ready_en;

  assign class_ok     = in_valid && $onehot(in_class);
  assign target_avail = |(in_class & avail);

`ifdef DISPATCH_SERIALIZE_EN
  assign serial_hold = in_serial && !rob_empty;
`else
  logic unused_serial;
  assign unused_serial = in_serial ^ rob_empty;
  assign serial_hold   = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    push_en  = 1'b0;
    ready_en = 1'b0;
    is_inst2 = 1'b0;
    if (flush) begin
      state_d = ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (class_ok && serial_hold) begin
`ifdef DISPATCH_SERIALIZE_EN
            state_d = ST_SERIAL_WAIT;
`endif
          end else if (class_ok && target_avail) begin
            push_en = 1'b1;
            if (in_dual) state_d  = ST_SECOND;
            else         ready_en = 1'b1;
          end
        end
        ST_SECOND: begin
          is_inst2 = 1'b1;
          if (class_ok && target_avail) begin
            push_en  = 1'b1;
            ready_en = 1'b1;
            state_d  = ST_RUN;
          end
        end
`ifdef DISPATCH_SERIALIZE_EN
        ST_SERIAL_WAIT: begin
          if (class_ok && rob_empty && target_avail) begin
            push_en  = 1'b1;
            ready_en = 1'b1;
            state_d  = ST_RUN;
          end
        end
`endif
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= ST_RUN;
    else         state_q <= state_d;
  end

  assign q_push   = (push_en && resetn) ? in_class : '0;
  assign in_ready = ready_en && resetn;

  for (genvar g = 0; g < NUM_FU; g++) begin : g_credit
    dispatch_credit #(.QDEPTH(QDEPTH)) u_credit (
      .clk    (clk),
      .resetn (resetn),
      .flush  (flush),
      .push   (q_push[g]),
      .free   (q_free[g]),
      .credit (credit[g]),
      .avail  (avail[g])
    );
  end

  a_class_onehot: assert property (@(posedge clk) disable iff (!resetn || flush)
    in_valid |-> $onehot(in_class));
endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl with hand-computed expectations.
module tb_dispatch_ctrl;
  import dispatch_ctrl_pkg::*;

  localparam int QD = 8;

  logic       clk = 1'b0;
  logic       resetn, flush, rob_empty, in_valid, in_dual, in_serial;
  logic       in_ready, is_inst2;
  logic [5:0] in_class, q_push, q_free;
  int         checks = 0;
  int         errors = 0;

  dispatch_ctrl #(.QDEPTH(QD)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .rob_empty (rob_empty),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_class  (in_class),
    .in_dual   (in_dual),
    .in_serial (in_serial),
    .is_inst2  (is_inst2),
    .q_push    (q_push),
    .q_free    (q_free)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are examined 1 ns later.
  task automatic drive(input logic v, input logic [5:0] cls, input logic dual,
                       input logic serial, input logic rob, input logic [5:0] free,
                       input logic fl, input logic rn);
    @(negedge clk);
    in_valid  = v;
    in_class  = cls;
    in_dual   = dual;
    in_serial = serial;
    rob_empty = rob;
    q_free    = free;
    flush     = fl;
    resetn    = rn;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 6'b0, 1'b0, 1'b0, 1'b1, 6'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    drive(1'b1, 6'b000001, 1'b0, 1'b0, 1'b1, 6'b0, 1'b0, 1'b0);
    checks++; if (q_push !== 6'b0) begin errors++; $display("FAIL reset_push: got %b want %b", q_push, 6'b0); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", in_ready); end
    idle();
    checks++; if (dut.state_q !== ST_RUN) begin errors++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, ST_RUN); end
    checks++; if (is_inst2 !== 1'b0) begin errors++; $display("FAIL reset_inst2: got %b want 0", is_inst2); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (dut.credit[i] !== 4'd8) begin errors++; $display("FAIL reset_credit%0d: got %0d want 8", i, dut.credit[i]); end
    end
  endtask

  task automatic test_single();
    drive(1'b1, 6'b000001, 1'b0, 1'b0, 1'b1, 6'b0, 1'b0, 1'b1);
    checks++; if (q_push !== 6'b000001) begin errors++; $display("FAIL single_push: got %b want 000001", q_push); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", in_ready); end
    idle();
    checks++; if (q_push !== 6'b0) begin errors++; $display("FAIL idle_push: got %b want 000000", q_push); end
    checks++; if (dut.credit[FU_ALU1] !== 4'd7) begin errors++; $display("FAIL single_credit: got %0d want 7", dut.credit[FU_ALU1]); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'b000001, 1'b0, 1'b0, 1'b1, 6'b0, 1'b0, 1'b1);
      checks++; if (in_ready !== 1'b1 || q_push !== 6'b000001) begin errors++; $display("FAIL b2b_%0d: got ready %b push %b want 1 000001", i, in_ready, q_push); end
    end
    idle();
    checks++; if (dut.credit[FU_ALU1] !== 4'd4) begin errors++; $display("FAIL b2b_credit: got %0d want 4", dut.credit[FU_ALU1]); end
  endtask

  task automatic test_dual();
    drive(1'b1, 6'b000100, 1'b1, 1'b0, 1'b1, 6'b0, 1'b0, 1'b1);
    checks++; if (q_push !== 6'b000100) begin errors++; $display("FAIL dual0_push: got %b want 000100", q_push); end
    checks++; if (is_inst2 !== 1'b0) begin errors++; $display("FAIL dual0_inst2: got %b want 0", is_inst2); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL dual0_ready: got %b want 0", in_ready); end
    drive(1'b1, 6'b000100, 1'b1, 1'b0, 1'b1, 6'b0, 1'b0, 1'b1);
    checks++; if (q_push !== 6'b000100) begin errors++; $display("FAIL dual1_push: got %b want 000100", q_push); end
    checks++; if (is_inst2 !== 1'b1) begin errors++; $display("FAIL dual1_inst2: got %b want 1", is_inst2); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dual1_ready: got %b want 1", in_ready); end
    idle();
    checks++; if (dut.credit[FU_MULDIV] !== 4'd6) begin errors++; $display("FAIL dual_credit: got %0d want 6", dut.credit[FU_MULDIV]); end
    checks++; if (dut.state_q !== ST_RUN || is_inst2 !== 1'b0) begin errors++; $display("FAIL dual_end: got state %0d inst2 %b want %0d 0", dut.state_q, is_inst2, ST_RUN); end
  endtask

  task automatic test_credit_limit();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 6'b010000, 1'b0, 1'b0, 1'b1, 6'b0, 1'b0, 1'b1);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lsu_push%0d: got ready %b want 1", i, in_ready); end
    end
    drive(1'b1, 6'b010000, 1'b0, 1'b0, 1'b1, 6'b0, 1'b0, 1'b1);
    checks++; if (in_ready !== 1'b0 || q_push !== 6'b0) begin errors++; $display("FAIL lsu_stall: got ready %b push %b want 0 000000", in_ready, q_push); end
    checks++; if (dut.credit[FU_LSU] !== 4'd0) begin errors++; $display("FAIL lsu_empty: got %0d want 0", dut.credit[FU_LSU]); end
    drive(1'b1, 6'b010000, 1'b0, 1'b0, 1'b1, 6'b010000, 1'b0, 1'b1);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lsu_free_cycle: got ready %b want 0", in_ready); end
    drive(1'b1, 6'b010000, 1'b0, 1'b0, 1'b1, 6'b0, 1'b0, 1'b1);
    checks++; if (in_ready !== 1'b1 || q_push !== 6'b010000) begin errors++; $display("FAIL lsu_after_free: got ready %b push %b want 1 010000", in_ready, q_push); end
    drive(1'b0, 6'b0, 1'b0, 1'b0, 1'b1, 6'b010000, 1'b0, 1'b1);
    drive(1'b1, 6'b010000, 1'b0, 1'b0, 1'b1, 6'b010000, 1'b0, 1'b1);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lsu_push_free: got ready %b want 1", in_ready); end
    idle();
    checks++; if (dut.credit[FU_LSU] !== 4'd1) begin errors++; $display("FAIL lsu_unchanged: got %0d want 1", dut.credit[FU_LSU]); end
  endtask

  task automatic test_serial();
`ifdef DISPATCH_SERIALIZE_EN
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'b100000, 1'b0, 1'b1, 1'b0, 6'b0, 1'b0, 1'b1);
      checks++; if (q_push !== 6'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL serial_hold%0d: got push %b ready %b want 000000 0", i, q_push, in_ready); end
    end
    checks++; if (dut.state_q !== ST_SERIAL_WAIT) begin errors++; $display("FAIL serial_state: got %0d want %0d", dut.state_q, ST_SERIAL_WAIT); end
    drive(1'b1, 6'b100000, 1'b0, 1'b1, 1'b1, 6'b0, 1'b0, 1'b1);
    checks++; if (q_push !== 6'b100000 || in_ready !== 1'b1) begin errors++; $display("FAIL serial_release: got push %b ready %b want 100000 1", q_push, in_ready); end
    idle();
    checks++; if (dut.state_q !== ST_RUN) begin errors++; $display("FAIL serial_back_run: got %0d want %0d", dut.state_q, ST_RUN); end
    drive(1'b1, 6'b100000, 1'b0, 1'b1, 1'b1, 6'b0, 1'b0, 1'b1);
    checks++; if (q_push !== 6'b100000 || in_ready !== 1'b1) begin errors++; $display("FAIL serial_direct: got push %b ready %b want 100000 1", q_push, in_ready); end
    idle();
    checks++; if (dut.credit[FU_SP] !== 4'd6) begin errors++; $display("FAIL serial_credit: got %0d want 6", dut.credit[FU_SP]); end
`else
    drive(1'b1, 6'b100000, 1'b0, 1'b1, 1'b0, 6'b0, 1'b0, 1'b1);
    checks++; if (q_push !== 6'b100000 || in_ready !== 1'b1) begin errors++; $display("FAIL serial_immediate: got push %b ready %b want 100000 1", q_push, in_ready); end
    idle();
    checks++; if (dut.credit[FU_SP] !== 4'd7) begin errors++; $display("FAIL serial_credit: got %0d want 7", dut.credit[FU_SP]); end
`endif
  endtask

  task automatic test_flush();
    drive(1'b1, 6'b000010, 1'b1, 1'b0, 1'b1, 6'b0, 1'b0, 1'b1);
    checks++; if (q_push !== 6'b000010) begin errors++; $display("FAIL flush_first: got %b want 000010", q_push); end
    drive(1'b1, 6'b000010, 1'b1, 1'b0, 1'b1, 6'b111111, 1'b1, 1'b1);
    checks++; if (q_push !== 6'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL flush_cycle: got push %b ready %b want 000000 0", q_push, in_ready); end
    idle();
    checks++; if (dut.state_q !== ST_RUN || is_inst2 !== 1'b0) begin errors++; $display("FAIL flush_state: got state %0d inst2 %b want %0d 0", dut.state_q, is_inst2, ST_RUN); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (dut.credit[i] !== 4'd8) begin errors++; $display("FAIL flush_credit%0d: got %0d want 8", i, dut.credit[i]); end
    end
    drive(1'b1, 6'b000010, 1'b1, 1'b0, 1'b1, 6'b0, 1'b0, 1'b1);
    checks++; if (is_inst2 !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL flush_replay0: got inst2 %b ready %b want 0 0", is_inst2, in_ready); end
    drive(1'b1, 6'b000010, 1'b1, 1'b0, 1'b1, 6'b0, 1'b0, 1'b1);
    checks++; if (is_inst2 !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_replay1: got inst2 %b ready %b want 1 1", is_inst2, in_ready); end
    idle();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 6'b000001, 1'b1, 1'b0, 1'b1, 6'b0, 1'b0, 1'b1);
    drive(1'b1, 6'b000001, 1'b1, 1'b0, 1'b1, 6'b0, 1'b0, 1'b0);
    checks++; if (q_push !== 6'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL rst_dual: got push %b ready %b want 000000 0", q_push, in_ready); end
    idle();
    checks++; if (dut.state_q !== ST_RUN || is_inst2 !== 1'b0) begin errors++; $display("FAIL rst_dual_state: got state %0d inst2 %b want %0d 0", dut.state_q, is_inst2, ST_RUN); end
    checks++; if (dut.credit[FU_ALU1] !== 4'd8) begin errors++; $display("FAIL rst_dual_credit: got %0d want 8", dut.credit[FU_ALU1]); end
`ifdef DISPATCH_SERIALIZE_EN
    drive(1'b1, 6'b100000, 1'b0, 1'b1, 1'b0, 6'b0, 1'b0, 1'b1);
    drive(1'b1, 6'b100000, 1'b0, 1'b1, 1'b0, 6'b0, 1'b0, 1'b0);
    checks++; if (q_push !== 6'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL rst_serial: got push %b ready %b want 000000 0", q_push, in_ready); end
    idle();
    checks++; if (dut.state_q !== ST_RUN) begin errors++; $display("FAIL rst_serial_state: got %0d want %0d", dut.state_q, ST_RUN); end
`endif
    for (int i = 0; i < 6; i++) begin
      checks++; if (dut.credit[i] !== 4'd8) begin errors++; $display("FAIL rst_credit%0d: got %0d want 8", i, dut.credit[i]); end
    end
  endtask

  initial begin
    resetn    = 1'b0;
    flush     = 1'b0;
    rob_empty = 1'b1;
    in_valid  = 1'b1;
    in_class  = 6'b000001;
    in_dual   = 1'b0;
    in_serial = 1'b0;
    q_free    = 6'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_dual();
    test_credit_limit();
    test_serial();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
